// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg                                                              |
// | Shared AES types, constants and inverse-cipher byte transforms.      |
// | Rev 1.0 - inverse S-box, InvSubBytes and InvShiftRows helpers        |
// +----------------------------------------------------------------------+
// The 128-bit block is laid out in FIPS-197 order: byte k (0..15) occupies
// bits [127-8k -: 8], and byte k sits at row k%4, column k/4 of the state.
package aes_pkg;

   typedef logic [127:0] aes_128;

   localparam int AES_NR    = 10;
   localparam int AES_RND_W = 4;

   // Inverse S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] INV_SBOX_LUT = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Entry x lives at bit offset (255-x)*8, and 255-x is simply ~x.
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX_LUT[{~x, 3'b000} +: 8];
   endfunction

   function automatic aes_128 inv_sub_bytes(input aes_128 s);
      aes_128 o;
      for (int k = 0; k < 16; k++) begin
         o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
      end
      return o;
   endfunction

   // Row r is rotated right by r byte positions.
   function automatic aes_128 inv_shift_rows(input aes_128 s);
      aes_128 o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
         end
      end
      return o;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_mix_column.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_inv_mix_column                                                   |
// | Combinational InvMixColumns over all four columns of a 128-bit state.|
// | Rev 1.0 - initial GF(2^8) {0e,0b,0d,09} column multiply              |
// +----------------------------------------------------------------------+
module aes_inv_mix_column (
   input  logic [127:0] data_i,
   output logic [127:0] data_o
);

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   // Column c holds bytes 4c..4c+3, row 0 in the most significant byte.
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = data_i[127-32*c -: 8];
      assign a1 = data_i[119-32*c -: 8];
      assign a2 = data_i[111-32*c -: 8];
      assign a3 = data_i[103-32*c -: 8];
      assign data_o[127-32*c -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      assign data_o[119-32*c -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      assign data_o[111-32*c -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      assign data_o[103-32*c -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
   end

endmodule
`default_nettype wire

// File: rtl/aes_dec_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_dec_iter                                                         |
// | Iterative AES-128 inverse cipher, one inverse round per clock.       |
// | Rev 1.0 - IDLE/ROUND/FINAL/DONE sequencer over a shared round path   |
// +----------------------------------------------------------------------+
module aes_dec_iter
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int RND_W = AES_RND_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  aes_128           cipher_i,
   output logic [RND_W-1:0] rnd_idx_o,
   input  aes_128           rnd_key_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output aes_128           plain_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   aes_128           st_q, st_d;
   logic [RND_W-1:0] rnd_q, rnd_d;

   aes_128           ark;
   aes_128           imc;

   // Shared round datapath: the final round taps ark, full rounds take imc.
   assign ark = inv_sub_bytes(inv_shift_rows(st_q)) ^ rnd_key_i;

   aes_inv_mix_column u_inv_mix (
      .data_i (ark),
      .data_o (imc)
   );

   assign plain_o = st_q;

   // State, block and round-counter registers; reset discards any block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         st_q    <= '0;
         rnd_q   <= RND_W'(NR);
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         rnd_q   <= rnd_d;
      end
   end

   // Next-state and output decode; outputs depend only on registered state.
   always_comb begin
      state_d     = state_q;
      st_d        = st_q;
      rnd_d       = rnd_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      rnd_idx_o   = '0;
      case (state_q)
         S_IDLE: begin
            in_ready_o = 1'b1;
            rnd_idx_o  = RND_W'(NR);
            if (in_valid_i) begin
               st_d    = cipher_i ^ rnd_key_i;
               rnd_d   = RND_W'(NR - 1);
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            rnd_idx_o = rnd_q;
            st_d      = imc;
            rnd_d     = rnd_q - RND_W'(1);
            if (rnd_q == RND_W'(1)) begin
               state_d = S_FINAL;
            end
         end
         S_FINAL: begin
            rnd_idx_o = '0;
            st_d      = ark;
            state_d   = S_DONE;
         end
         S_DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               rnd_d   = RND_W'(NR);
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_dec_iter                                                      |
// | Directed self-checking bench for the iterative AES-128 decryptor.    |
// | Rev 1.0 - FIPS vectors, backpressure, back-to-back, reset, stalls    |
// +----------------------------------------------------------------------+
module tb_aes_dec_iter;

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] cipher;
   logic [3:0]   rnd_idx;
   logic [127:0] rnd_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plain;

   int n_pass  = 0;
   int n_total = 0;

   logic [127:0] rk [0:10];
   logic [7:0]   sbox_t [0:255];

   always #5 clk = ~clk;

   // Key-storage model: combinational lookup of the requested round key.
   assign rnd_key = (rnd_idx <= 4'd10) ? rk[rnd_idx] : 128'h0;

   aes_dec_iter dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .cipher_i    (cipher),
      .rnd_idx_o   (rnd_idx),
      .rnd_key_i   (rnd_key),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .plain_o     (plain)
   );

   // ---------------- forward-cipher reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      if (x == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   task automatic set_key(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s;
      logic [127:0] t;
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ rk[0];
      for (int r = 1; r <= 10; r++) begin
         for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox_t[s[127-8*k -: 8]];
         t = s;
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               s[127-8*(rr+4*c) -: 8] = t[127-8*(rr+4*((c+rr)%4)) -: 8];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
               a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
               s[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         s = s ^ rk[r];
      end
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for in_ready, hands over one block, then waits for out_valid.
   // lat is the edge count from accept to out_valid, or -1 on timeout.
   task automatic send_and_wait(input logic [127:0] ct, output logic [127:0] got,
                                output int lat);
      int n = 0;
      while (!in_ready && n < 100) begin step(); n++; end
      in_valid = 1'b1;
      cipher   = ct;
      step();
      in_valid = 1'b0;
      cipher   = rand128();
      lat = 0;
      while (!out_valid && lat < 40) begin step(); lat++; end
      if (!out_valid) lat = -1;
      got = plain;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cipher = '0;
      step(); step();
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_total++; if (plain !== 128'h0) $display("FAIL reset_plain got %h want 0", plain); else n_pass++;
      n_total++; if (rnd_idx !== 4'd10) $display("FAIL reset_rnd_idx got %0d want 10", rnd_idx); else n_pass++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_fips_c1();
      set_key(K_C1);
      out_ready = 1'b1;
      n_total++; if (rnd_idx !== 4'd10) $display("FAIL c1_idle_idx got %0d want 10", rnd_idx); else n_pass++;
      in_valid = 1'b1;
      cipher   = CT_C1;
      step();
      in_valid = 1'b0;
      for (int j = 0; j < 10; j++) begin
         logic [3:0] exp_idx;
         exp_idx = (j == 9) ? 4'd0 : 4'(9 - j);
         n_total++; if (rnd_idx !== exp_idx) $display("FAIL c1_rnd_idx cycle %0d got %0d want %0d", j, rnd_idx, exp_idx); else n_pass++;
         n_total++; if (out_valid !== 1'b0) $display("FAIL c1_early_valid cycle %0d got %b want 0", j, out_valid); else n_pass++;
         step();
      end
      n_total++; if (out_valid !== 1'b1) $display("FAIL c1_latency out_valid got %b want 1", out_valid); else n_pass++;
      n_total++; if (plain !== PT_C1) $display("FAIL c1_plain got %h want %h", plain, PT_C1); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL c1_done_ready got %b want 0", in_ready); else n_pass++;
      step();
      n_total++; if (in_ready !== 1'b1) $display("FAIL c1_back_idle got %b want 1", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL c1_valid_drop got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_fips_b();
      logic [127:0] got;
      int lat;
      set_key(K_B);
      out_ready = 1'b1;
      send_and_wait(CT_B, got, lat);
      n_total++; if (lat !== 10) $display("FAIL b_latency got %0d want 10", lat); else n_pass++;
      n_total++; if (got !== PT_B) $display("FAIL b_plain got %h want %h", got, PT_B); else n_pass++;
      step();
   endtask

   task automatic test_backpressure();
      logic [127:0] got, pt2, ct2;
      int lat;
      set_key(K_C1);
      pt2 = rand128();
      ct2 = encrypt(pt2);
      out_ready = 1'b0;
      send_and_wait(CT_C1, got, lat);
      n_total++; if (got !== PT_C1) $display("FAIL bp_first_plain got %h want %h", got, PT_C1); else n_pass++;
      in_valid = 1'b1;
      cipher   = ct2;
      for (int j = 0; j < 20; j++) begin
         step();
         n_total++; if (plain !== PT_C1) $display("FAIL bp_hold_plain cycle %0d got %h want %h", j, plain, PT_C1); else n_pass++;
         n_total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready cycle %0d got %b want 0", j, in_ready); else n_pass++;
         n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cycle %0d got %b want 1", j, out_valid); else n_pass++;
      end
      out_ready = 1'b1;
      step();
      n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", out_valid); else n_pass++;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin step(); lat++; end
      n_total++; if (lat !== 10) $display("FAIL bp_second_latency got %0d want 10", lat); else n_pass++;
      n_total++; if (plain !== pt2) $display("FAIL bp_second_plain got %h want %h", plain, pt2); else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      logic [127:0] pts [0:3];
      logic [127:0] cts [0:3];
      int out_cyc [0:3];
      int idx_in = 0;
      int idx_out = 0;
      int cyc = 0;
      logic acc;
      set_key(rand128());
      for (int i = 0; i < 4; i++) begin pts[i] = rand128(); cts[i] = encrypt(pts[i]); end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      cipher    = cts[0];
      while (idx_out < 4 && cyc < 200) begin
         acc = in_ready && in_valid;
         if (out_valid) begin
            n_total++; if (plain !== pts[idx_out]) $display("FAIL b2b_plain block %0d got %h want %h", idx_out, plain, pts[idx_out]); else n_pass++;
            out_cyc[idx_out] = cyc;
            idx_out++;
         end
         step();
         cyc++;
         if (acc) begin
            idx_in++;
            if (idx_in < 4) cipher = cts[idx_in];
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_total++; if (idx_out !== 4) $display("FAIL b2b_count got %0d want 4", idx_out); else n_pass++;
      for (int i = 1; i < idx_out; i++) begin
         n_total++; if (out_cyc[i] - out_cyc[i-1] !== 12) $display("FAIL b2b_spacing block %0d got %0d want 12", i, out_cyc[i] - out_cyc[i-1]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] got;
      int n = 0;
      int lat;
      bit stale = 1'b0;
      set_key(K_C1);
      out_ready = 1'b1;
      while (!in_ready && n < 50) begin step(); n++; end
      in_valid = 1'b1;
      cipher   = CT_C1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (rnd_idx !== 4'd5 && n < 20) begin step(); n++; end
      n_total++; if (rnd_idx !== 4'd5) $display("FAIL rst_mid_reach got %0d want 5", rnd_idx); else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", in_ready); else n_pass++;
      n_total++; if (plain !== 128'h0) $display("FAIL rst_mid_state got %h want 0", plain); else n_pass++;
      n_total++; if (rnd_idx !== 4'd10) $display("FAIL rst_mid_idx got %0d want 10", rnd_idx); else n_pass++;
      for (int j = 0; j < 15; j++) begin
         if (out_valid) stale = 1'b1;
         step();
      end
      n_total++; if (stale !== 1'b0) $display("FAIL rst_mid_stale got %b want 0", stale); else n_pass++;
      send_and_wait(CT_C1, got, lat);
      n_total++; if (lat !== 10) $display("FAIL rst_mid_fresh_latency got %0d want 10", lat); else n_pass++;
      n_total++; if (got !== PT_C1) $display("FAIL rst_mid_fresh_plain got %h want %h", got, PT_C1); else n_pass++;
      step();
   endtask

   task automatic test_input_stall();
      logic [127:0] x_pt, x_ct;
      int acc_n = 0;
      int n_out = 0;
      logic acc;
      set_key(K_C1);
      x_pt = rand128();
      x_ct = encrypt(x_pt);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && n_out < 2; cyc++) begin
         if (out_valid) begin
            if (n_out == 0) begin
               n_total++; if (plain !== x_pt) $display("FAIL stall_first_plain got %h want %h", plain, x_pt); else n_pass++;
            end else begin
               n_total++; if (plain !== PT_C1) $display("FAIL stall_second_plain got %h want %h", plain, PT_C1); else n_pass++;
            end
            n_out++;
         end
         in_valid = (acc_n < 2);
         if (in_ready) cipher = (acc_n == 0) ? x_ct : CT_C1;
         else          cipher = rand128();
         acc = in_ready && in_valid;
         step();
         if (acc) acc_n++;
      end
      in_valid = 1'b0;
      n_total++; if (n_out !== 2) $display("FAIL stall_out_count got %0d want 2", n_out); else n_pass++;
      n_total++; if (acc_n !== 2) $display("FAIL stall_accept_count got %0d want 2", acc_n); else n_pass++;
      step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
      for (int r = 0; r <= 10; r++) rk[r] = '0;
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_input_stall();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_dec_iter.md
Name: aes_dec_iter

Overview:
- Iterative AES-128 inverse cipher: the decryption counterpart of the encryption round datapath.
- Accepts one 128-bit ciphertext block over a valid/ready handshake and runs 10 inverse rounds, one per clock, on a single shared round datapath.
- Returns the plaintext over a second valid/ready handshake.
- Round keys come from the external key-schedule storage, indexed by the round number this block drives.

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported).
- RND_W, 4, width of the round-index output.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid_i  input  1  ciphertext valid
- in_ready_o  output  1  block can accept a ciphertext
- cipher_i  input  128  ciphertext block (aes_pkg::aes_128)
- rnd_idx_o  output  RND_W  round-key index requested this cycle
- rnd_key_i  input  128  round key for rnd_idx_o, combinational same-cycle from key storage
- out_valid_o  output  1  plaintext valid
- out_ready_i  input  1  consumer accepts plaintext
- plain_o  output  128  plaintext block (aes_pkg::aes_128)

Behaviour:
- State register st (128 b), round counter rnd (RND_W), FSM {IDLE, ROUND, FINAL, DONE}.
- Reset (rst=1 at a clock edge):
  - FSM=IDLE, st=0, rnd=NR.
  - in_ready_o=1 in the cycle after reset; out_valid_o=0; plain_o=0.
  - Reset overrides everything, including mid-operation; an in-flight block is discarded with no output.
- IDLE:
  - in_ready_o=1, rnd_idx_o=NR.
  - On in_valid_i&in_ready_o: st<=cipher_i^rnd_key_i (initial AddRoundKey with rk10), rnd<=NR-1, go ROUND.
- ROUND:
  - rnd_idx_o=rnd.
  - st<=InvMixColumns(InvSubBytes(InvShiftRows(st))^rnd_key_i).
  - rnd<=rnd-1.
  - If rnd==1, go FINAL (rnd becomes 0).
- FINAL:
  - rnd_idx_o=0.
  - st<=InvSubBytes(InvShiftRows(st))^rnd_key_i, with no InvMixColumns.
  - Go DONE.
- DONE:
  - out_valid_o=1, plain_o=st, in_ready_o=0.
  - plain_o is held stable while out_valid_o=1 and out_ready_i=0; backpressure is unbounded.
  - On out_ready_i: go IDLE, rnd<=NR.
- in_ready_o=1 only in IDLE. There is no overlap of accept and drain; a new block is accepted at the earliest in the cycle after the DONE handshake.
- Latency: accept at edge t gives out_valid_o=1 after edge t+10 (9 ROUND cycles + 1 FINAL); at least 12 cycles per block.
- rnd_idx_o is a registered-state decode and is valid all cycles. In DONE it drives 0, and its value there is don't-care for key storage.
- in_valid_i while in_ready_o=0 is ignored; the source must hold it.
- out_valid_o and plain_o are driven from registers only.

Decomposition:
- aes_pkg gains:
  - inv_sbox function (256-entry LUT)
  - inv_sub_bytes function
  - inv_shift_rows function (row r rotated right by r bytes)
  - localparams AES_NR=10 and AES_RND_W=4
  - existing aes_128 type reused
- One sub-module, aes_inv_mix_column: combinational GF(2^8) multiply by {0e,0b,0d,09} per column, 128-bit in/out.
- FSM, counter and muxing live in aes_dec_iter.

Test Plan:
- FIPS-197 C.1 vector:
  - Bench key-storage model expands key 000102030405060708090a0b0c0d0e0f.
  - Send cipher 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expect plain_o=00112233445566778899aabbccddeeff, out_valid_o rising exactly 10 edges after accept.
  - Expect rnd_idx_o sequence 10,9,...,1,0.
- Appendix B vector:
  - Key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32.
  - Expect plain 3243f6a8885a308d313198a2e0370734.
- Backpressure:
  - Hold out_ready_i=0 for 20 cycles after out_valid_o.
  - Expect plain_o stable, in_ready_o=0, and a second in_valid_i ignored.
  - Then out_ready_i=1 gives IDLE next cycle; the second block is accepted and decrypts correctly.
- Back-to-back: out_ready_i tied 1 with 4 random blocks; expect 12-cycle spacing and each result matching the reference model.
- Reset mid-operation:
  - Assert rst in ROUND at rnd=5.
  - Expect out_valid_o=0, in_ready_o=1, st=0 next cycle, with no stale output.
  - A fresh C.1 block then decrypts correctly.
- Input stalls: in_valid_i held with changing cipher_i while busy; only the value present at the handshake edge is decrypted.
